// File: rtl/load_store_unit.sv
// Multi-cycle RISC-V load/store unit: decodes funct3, extracts and extends load lanes,
// and performs byte/halfword stores as read-modify-write on a 32-bit word memory.

module lsu_lane_merge #(
  parameter int LANE = 0
) (
  input  logic        half_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [15:0] src_i,
  input  logic [7:0]  old_i,
  output logic [7:0]  byte_o
);
  localparam logic [1:0] L = 2'(LANE);

  logic       hit;
  logic [7:0] src;

  always_comb begin
    hit    = half_i ? (addr_lo_i[1] == L[1]) : (addr_lo_i == L);
    // Odd lanes of a halfword take the upper store byte.
    src    = (half_i && L[0]) ? src_i[15:8] : src_i[7:0];
    byte_o = hit ? src : old_i;
  end
endmodule

module load_store_unit #(
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              resp_valid_o,
  output logic [31:0]       resp_rdata_o,
  output logic              resp_fault_o,
  output logic [7:0]        mem_addr_o,
  output logic [31:0]       mem_write_data_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  input  logic [31:0]       mem_read_data_i
);
  localparam int NUM_LANES = 4;

  typedef enum logic [2:0] {IDLE, LOAD, RMW_READ, WRITE, RESP} state_e;

  typedef struct packed {
    logic              write;
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] addr;
  } req_t;

  state_e      state_q, state_d;
  req_t        req_q, req_d;
  logic [31:0] wbuf_q, wbuf_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;

  logic        illegal, misalign, acc_fault;
  logic        mem_active;
  logic [5:0]  widx;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;
  logic [NUM_LANES-1:0][7:0] merged;

  // Fault decode on the raw request so a bad access never reaches memory.
  always_comb begin
    illegal   = (req_funct3_i[1:0] == 2'b11) |
                (req_funct3_i[2] & (req_write_i | req_funct3_i[1]));
    misalign  = ((req_funct3_i[1:0] == 2'b01) & req_addr_i[0]) |
                ((req_funct3_i[1:0] == 2'b10) & (req_addr_i[1:0] != 2'b00));
    acc_fault = illegal | misalign;
  end

  always_comb begin
    byte_sel = mem_read_data_i[{req_q.addr[1:0], 3'b000} +: 8];
    half_sel = mem_read_data_i[{req_q.addr[1], 4'b0000} +: 16];
    case (req_q.funct3)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_ext = {24'd0, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_ext = {16'd0, half_sel};
      default: load_ext = mem_read_data_i;
    endcase
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lsu_lane_merge #(.LANE(g)) u_lane (
      .half_i    (req_q.funct3[0]),
      .addr_lo_i (req_q.addr[1:0]),
      .src_i     (wbuf_q[15:0]),
      .old_i     (mem_read_data_i[8*g +: 8]),
      .byte_o    (merged[g])
    );
  end

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    wbuf_d       = wbuf_q;
    rdata_d      = rdata_q;
    fault_d      = fault_q;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    mem_active   = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          req_d.write  = req_write_i;
          req_d.funct3 = req_funct3_i;
          req_d.addr   = req_addr_i;
          wbuf_d       = req_wdata_i;
          if (acc_fault) begin
            state_d = RESP;
            fault_d = 1'b1;
            rdata_d = '0;
          end else if (!req_write_i) begin
            state_d = LOAD;
          end else if (req_funct3_i[1]) begin
            state_d = WRITE;
          end else begin
            state_d = RMW_READ;
          end
        end
      end
      LOAD: begin
        mem_read_o = 1'b1;
        mem_active = 1'b1;
        rdata_d    = load_ext;
        fault_d    = 1'b0;
        state_d    = RESP;
      end
      RMW_READ: begin
        mem_read_o = 1'b1;
        mem_active = 1'b1;
        wbuf_d     = merged;
        state_d    = WRITE;
      end
      WRITE: begin
        mem_write_o = 1'b1;
        mem_active  = 1'b1;
        rdata_d     = '0;
        fault_d     = 1'b0;
        state_d     = RESP;
      end
      RESP: begin
        resp_valid_o = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign widx             = 6'(req_q.addr[ADDR_W-1:2]);
  assign mem_addr_o       = mem_active ? {2'b00, widx} : 8'd0;
  assign mem_write_data_o = (state_q == WRITE) ? wbuf_q : 32'd0;
  assign resp_rdata_o     = rdata_q;
  assign resp_fault_o     = fault_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      req_q   <= '0;
      wbuf_q  <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      wbuf_q  <= wbuf_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: vector table driven through a scoreboard, with a word
// memory model, plus hand-written stall and mid-RMW reset sequences.

module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [7:0]  req_addr = 8'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [7:0]  mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_read_data;

  logic [31:0] mem [64] = '{default: 32'd0};

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_write) mem[mem_addr[5:0]] <= mem_write_data;
  assign mem_read_data = mem[mem_addr[5:0]];

  load_store_unit #(.ADDR_W(8)) dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_write_i      (req_write),
    .req_funct3_i     (req_funct3),
    .req_addr_i       (req_addr),
    .req_wdata_i      (req_wdata),
    .resp_valid_o     (resp_valid),
    .resp_rdata_o     (resp_rdata),
    .resp_fault_o     (resp_fault),
    .mem_addr_o       (mem_addr),
    .mem_write_data_o (mem_write_data),
    .mem_read_o       (mem_read),
    .mem_write_o      (mem_write),
    .mem_read_data_i  (mem_read_data)
  );

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        fault;
    int          lat;
    int          nrd;
    int          nwr;
    logic [7:0]  waddr;
    logic [31:0] wword;
  } vec_t;

  typedef struct {
    vec_t   v;
    longint t_acc;
    int     id;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   n_chk = 0, n_pass = 0;
  int   rd_cnt = 0, wr_cnt = 0, idle_viol = 0;
  int   lat;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
  endtask

  function automatic vec_t ld(input logic [2:0] f3, input logic [7:0] a, input logic [31:0] rd);
    vec_t v = '{wr: 1'b0, f3: f3, addr: a, wdata: 32'd0, rdata: rd, fault: 1'b0,
                lat: 2, nrd: 1, nwr: 0, waddr: 8'd0, wword: 32'd0};
    return v;
  endfunction

  function automatic vec_t st(input logic [2:0] f3, input logic [7:0] a, input logic [31:0] wd,
                              input logic [31:0] word);
    vec_t v = '{wr: 1'b1, f3: f3, addr: a, wdata: wd, rdata: 32'd0, fault: 1'b0,
                lat: (f3 == 3'b010) ? 2 : 3, nrd: (f3 == 3'b010) ? 0 : 1, nwr: 1,
                waddr: {2'b00, a[7:2]}, wword: word};
    return v;
  endfunction

  function automatic vec_t flt(input logic wr, input logic [2:0] f3, input logic [7:0] a);
    vec_t v = '{wr: wr, f3: f3, addr: a, wdata: 32'hFFFF_FFFF, rdata: 32'd0, fault: 1'b1,
                lat: 1, nrd: 0, nwr: 0, waddr: 8'd0, wword: 32'd0};
    return v;
  endfunction

  // Monitor: counts memory activity per transaction and scores each response.
  always @(negedge clk) begin
    if (reset) begin
      rd_cnt = 0;
      wr_cnt = 0;
    end else begin
      if (mem_read) rd_cnt++;
      if (mem_write) begin
        wr_cnt++;
        if (sbq.size() > 0) begin
          chk($sformatf("v%0d_waddr", sbq[0].id), {24'd0, mem_addr}, {24'd0, sbq[0].v.waddr});
          chk($sformatf("v%0d_wdata", sbq[0].id), mem_write_data, sbq[0].v.wword);
        end else chk("stray_write", 32'(sbq.size()), 32'd1);
      end
      if (req_ready && (mem_read || mem_write || mem_addr != 8'd0 ||
                        mem_write_data != 32'd0 || resp_valid)) idle_viol++;
      if (resp_valid) begin
        if (sbq.size() == 0) chk("spurious_resp", 32'(sbq.size()), 32'd1);
        else begin
          e   = sbq.pop_front();
          lat = int'((longint'($time) - e.t_acc + 5) / 10);
          chk($sformatf("v%0d_rdata", e.id), resp_rdata, e.v.rdata);
          chk($sformatf("v%0d_fault", e.id), {31'd0, resp_fault}, {31'd0, e.v.fault});
          chk($sformatf("v%0d_latency", e.id), 32'(lat), 32'(e.v.lat));
          chk($sformatf("v%0d_reads", e.id), 32'(rd_cnt), 32'(e.v.nrd));
          chk($sformatf("v%0d_writes", e.id), 32'(wr_cnt), 32'(e.v.nwr));
          rd_cnt = 0;
          wr_cnt = 0;
        end
      end
    end
  end

  task automatic do_req(input vec_t v, input int id);
    int guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      chk($sformatf("v%0d_ready_timeout", id), {31'd0, req_ready}, 32'd1);
      return;
    end
    req_valid  = 1'b1;
    req_write  = v.wr;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    @(posedge clk);
    sbq.push_back('{v: v, t_acc: longint'($time), id: id});
    #1;
    req_valid  = 1'b0;
    req_write  = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = 8'($urandom);
    req_wdata  = $urandom;
  endtask

  task automatic drain(input string nm);
    int guard = 0;
    while (sbq.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    chk(nm, 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    vec_t   vt[24];
    vec_t   v;
    longint t1;
    int     guard;

    vt[0]  = st(3'b010, 8'h14, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    vt[1]  = ld(3'b000, 8'h15, 32'hFFFF_FFBE);
    vt[2]  = ld(3'b100, 8'h17, 32'h0000_00DE);
    vt[3]  = ld(3'b001, 8'h16, 32'hFFFF_DEAD);
    vt[4]  = ld(3'b101, 8'h14, 32'h0000_BEEF);
    vt[5]  = ld(3'b010, 8'h14, 32'hDEAD_BEEF);
    vt[6]  = st(3'b000, 8'h16, 32'h1234_5655, 32'hDE55_BEEF);
    vt[7]  = ld(3'b010, 8'h14, 32'hDE55_BEEF);
    vt[8]  = st(3'b001, 8'h14, 32'h0000_A5A5, 32'hDE55_A5A5);
    vt[9]  = ld(3'b010, 8'h14, 32'hDE55_A5A5);
    vt[10] = flt(1'b1, 3'b001, 8'h13);
    vt[11] = flt(1'b0, 3'b010, 8'h16);
    vt[12] = flt(1'b0, 3'b011, 8'h14);
    vt[13] = flt(1'b1, 3'b100, 8'h14);
    vt[14] = flt(1'b0, 3'b110, 8'h14);
    vt[15] = flt(1'b0, 3'b001, 8'h15);
    vt[16] = ld(3'b000, 8'h16, 32'h0000_0055);
    vt[17] = ld(3'b001, 8'h16, 32'hFFFF_DE55);
    vt[18] = st(3'b000, 8'h01, 32'hAAAA_AA80, 32'h0000_8000);
    vt[19] = ld(3'b000, 8'h01, 32'hFFFF_FF80);
    vt[20] = st(3'b001, 8'h1A, 32'hCAFE_1234, 32'h1234_0000);
    vt[21] = ld(3'b010, 8'h18, 32'h1234_0000);
    vt[22] = ld(3'b101, 8'h1A, 32'h0000_1234);
    vt[23] = flt(1'b1, 3'b010, 8'h1A);

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_fault", {31'd0, resp_fault}, 32'd0);
    chk("rst_mem_ctl", {30'd0, mem_read, mem_write}, 32'd0);
    chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", mem_write_data, 32'd0);

    for (int i = 0; i < 24; i++) do_req(vt[i], i);
    drain("table_drain");

    // Second request held on req_valid while an SB is in flight.
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 8'h17;
    req_wdata  = 32'h0000_0077;
    @(posedge clk);
    sbq.push_back('{v: st(3'b000, 8'h17, 32'h77, 32'h7755_A5A5), t_acc: longint'($time), id: 100});
    t1 = longint'($time);
    #1;
    req_write  = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 8'h14;
    req_wdata  = 32'h0;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!req_ready && guard < 20);
    @(posedge clk);
    sbq.push_back('{v: ld(3'b010, 8'h14, 32'h7755_A5A5), t_acc: longint'($time), id: 101});
    chk("stall_accept_time", 32'(longint'($time) - t1), 32'd40);
    #1 req_valid = 1'b0;
    drain("stall_drain");

    // Reset arriving while an SB sits in RMW_READ must abandon the write.
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 8'h14;
    req_wdata  = 32'h0000_00FF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    chk("rmw_read_active", {31'd0, mem_read}, 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rmw_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rmw_rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("rmw_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rmw_rst_rdata", resp_rdata, 32'd0);
    repeat (3) @(negedge clk);
    v = ld(3'b010, 8'h14, 32'h7755_A5A5);
    do_req(v, 200);
    drain("final_drain");

    chk("idle_outputs", 32'(idle_viol), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit between the core's execute stage and `data_memory`. Accepts one RISC-V load or store per handshake and decodes `funct3`. Performs byte and halfword stores as read-modify-write on the 32-bit word memory. Extracts and sign- or zero-extends load data, and flags misaligned or illegal accesses without touching memory.

## Interface
Parameters:
- `ADDR_W`, 8: byte-address width of core requests; word index is `req_addr[ADDR_W-1:2]`.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  core presents a request.
- `req_ready`  out  1  unit can accept; high only in IDLE.
- `req_write`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RISC-V funct3.
  - Loads: LB 000, LH 001, LW 010, LBU 100, LHU 101.
  - Stores: SB 000, SH 001, SW 010.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  32  store data; low byte/halfword used for SB/SH.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  extended load data; 0 for stores and faults.
- `resp_fault`  out  1  valid with `resp_valid`: misaligned or illegal funct3.
- `mem_addr`  out  8  word index in [5:0]; [7:6] = 0.
- `mem_write_data`  out  32  word to write.
- `mem_read`  out  1  memory read enable.
- `mem_write`  out  1  memory write enable; memory writes on the rising edge while high.
- `mem_read_data`  in  32  asynchronous read data, valid in the same cycle as `mem_read`.

## Operation
- Acceptance: `req_valid && req_ready` on a rising edge. All request fields are captured on that edge; inputs are don't-care afterwards.
- FSM states: IDLE, LOAD, RMW_READ, WRITE, RESP.
- Transitions on accept from IDLE:
  - Fault → RESP with fault set.
  - Load → LOAD.
  - SW → WRITE with buffer = `req_wdata`.
  - SB/SH → RMW_READ.
- LOAD: `mem_read`=1. Extract the lane, extend it, register it into `resp_rdata`. → RESP.
- RMW_READ: `mem_read`=1. Merge the store lane into `mem_read_data` and register the result in the write buffer. → WRITE.
- WRITE: `mem_write`=1, `mem_write_data` = buffer. → RESP.
- RESP: `resp_valid`=1, `req_ready`=0. → IDLE.
- Lane rules (little-endian):
  - Byte = `word[8*a[1:0] +: 8]`.
  - Half = `word[16*a[1] +: 16]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - SB/SH replace only the addressed lane; the other bytes are preserved.
- Fault conditions: halfword access with `a[0]`=1; word access with `a[1:0]`≠0; load funct3 011/11x; store funct3 1xx/011.
- On fault: no `mem_read`/`mem_write` is ever asserted, `resp_rdata`=0, `resp_fault`=1.
- Idle outputs: when not in LOAD/RMW_READ/WRITE, `mem_read`=`mem_write`=0 and `mem_addr`=`mem_write_data`=0.
- Response hold: `resp_rdata`/`resp_fault` hold their last value until the next RESP.

## Timing
- Reset: on a rising edge with `reset`=1 the unit goes to IDLE and clears all registers.
  - Post-reset outputs: `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_fault`=0, `mem_*`=0.
  - Reset overrides any state, including mid-RMW. No `mem_write` occurs in the cycle after the reset edge.
- Latency, counted in cycles after the accept edge until the cycle in which `resp_valid` is high:
  - Fault: 1.
  - Load: 2.
  - SW: 2.
  - SB/SH: 3.
- Throughput: `req_ready` returns high the cycle after RESP. The next accept can occur on the edge that ends RESP+1, so back-to-back requests need no gap beyond the FSM.
- Stall rule: `req_valid` while `req_ready`=0 is ignored. The core holds it (single-cycle core stalls its PC).
- Address stability: `mem_addr` is constant across RMW_READ→WRITE, so the read and the write hit the same word.

## Test plan
- Reset, then SW addr 0x14 data 0xDEADBEEF → `mem_write` pulses one cycle with `mem_addr`=5, `mem_write_data`=0xDEADBEEF; `resp_valid` 2 cycles after accept, `resp_fault`=0.
- Loads from word 5 = 0xDEADBEEF:
  - LB 0x15 → 0xFFFFFFBE.
  - LBU 0x17 → 0x000000DE.
  - LH 0x16 → 0xFFFFDEAD.
  - LHU 0x14 → 0x0000BEEF.
  - LW 0x14 → 0xDEADBEEF.
  - Each completes at latency 2.
- SB 0x16 data 0x12345655 → RMW_READ then WRITE of 0xDE55BEEF; a following LW 0x14 returns 0xDE55BEEF. Then SH 0x14 data 0x0000A5A5 → LW returns 0xDE55A5A5.
- Faults, no memory access:
  - SH 0x13 → `resp_fault`=1, `resp_rdata`=0, latency 1.
  - LW 0x16 → fault.
  - Load funct3 011 → fault.
  - Store funct3 100 → fault.
- Assert `reset` during RMW_READ of an SB 0x14 data 0xFF → no `mem_write` afterwards, `req_ready`=1 next cycle, LW 0x14 still returns the prior word.
- Hold `req_valid`=1 with a new request throughout a busy SB → the second request is accepted only the cycle after RESP. Both responses are correct, with exactly one `resp_valid` pulse each.
